vdp1_cmd_seq: RTL and testbench

VDP1 command-list sequencer. Walks the command tables in VDP1 VRAM: fetches each 32-byte table word by word, follows the END/JP/CMDLINK link fields with a one-level call stack, and hands complete tables to the draw engine over a valid/ready handshake. It maintains the COPR, LOPR, CEF and BEF register values and sits between the VRAM arbiter and the command execution datapath.

---
 rtl/vdp1_cmd_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_vdp1_cmd_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp1_cmd_seq.sv
// vdp1_cmd_seq -- VDP1 command-list sequencer.
//
// Walks the 32-byte command tables in VRAM: reads each table word by word,
// follows the END / JP / CMDLINK link fields with a one-level call stack and
// hands each complete drawable table to the draw engine. Maintains COPR, LOPR,
// CEF and BEF.
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   START           1-cycle pulse: restart the list at table 0
//   FRAME_SWAP      1-cycle pulse: BEF <= CEF, CEF <= 0
//   VRAM_A/VRAM_RD  word address and read request (held until VRAM_RDY)
//   VRAM_RDY/VRAM_D read completion and data (same cycle)
//   CMD_TBL         packed table, word 0 in bits [255:240], word 15 always 0
//   CMD_VALID/READY command handshake towards the draw engine
//   COPR, LOPR      current table address / address of the END table (bytes/8)
//   CEF, BEF        current / previous frame end flags
//   BUSY            sequencer is not idle
//   dbg_state       FSM state, for checkers
//
// Handshake: CMD_VALID rises once a table is fully captured and stays high,
// with CMD_TBL frozen, until the cycle where CMD_VALID & CMD_READY; that edge
// is the transfer. Only START withdraws CMD_VALID without a transfer.
module vdp1_cmd_seq #(
  parameter int TBL_WORDS = 15
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         FRAME_SWAP,
  output logic [17:0]  VRAM_A,
  output logic         VRAM_RD,
  input  logic         VRAM_RDY,
  input  logic [15:0]  VRAM_D,
  output logic [255:0] CMD_TBL,
  output logic         CMD_VALID,
  input  logic         CMD_READY,
  output logic [15:0]  COPR,
  output logic [15:0]  LOPR,
  output logic         CEF,
  output logic         BEF,
  output logic         BUSY,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CTRL  = 3'd1,
    RD_LINK  = 3'd2,
    RD_BODY  = 3'd3,
    DISPATCH = 3'd4,
    LINK     = 3'd5
  } state_t;

  localparam logic [3:0] LAST_W = 4'(TBL_WORDS - 1);

  state_t       state_q, state_n;
  logic [13:0]  t_q, t_n;
  logic [3:0]   w_q, w_n;
  logic         rd_q, rd_n;
  logic         cv_q, cv_n;
  logic         busy_q;
  logic         cef_q, cef_n;
  logic         bef_q, bef_n;
  logic [15:0]  lopr_q, lopr_n;
  logic [13:0]  stk_q, stk_n;
  logic         stk_vld_q, stk_vld_n;
  logic         cap_en;
  logic [15:0]  tbl_q [TBL_WORDS];
  logic [13:0]  t_inc;

  // Reserved bits of the control registers read back as zero.
  function automatic logic [15:0] word_mask(input logic [3:0] w);
    case (w)
      4'd0:    word_mask = 16'hFF3F;
      4'd1:    word_mask = 16'hFFFC;
      4'd2:    word_mask = 16'h9FFF;
      4'd5:    word_mask = 16'h3FFF;
      default: word_mask = 16'hFFFF;
    endcase
  endfunction

  // Drawing / clipping / coordinate commands; every other code is a no-op.
  function automatic logic comm_ok(input logic [3:0] c);
    case (c)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: comm_ok = 1'b1;
      default:                                             comm_ok = 1'b0;
    endcase
  endfunction

  assign t_inc = t_q + 14'd1;

  always_comb begin
    state_n   = state_q;
    t_n       = t_q;
    w_n       = w_q;
    rd_n      = rd_q;
    cv_n      = cv_q;
    cef_n     = cef_q;
    bef_n     = bef_q;
    lopr_n    = lopr_q;
    stk_n     = stk_q;
    stk_vld_n = stk_vld_q;
    cap_en    = 1'b0;

    if (FRAME_SWAP) begin
      bef_n = cef_q;
      cef_n = 1'b0;
    end

    if (START) begin
      state_n   = RD_CTRL;
      t_n       = '0;
      w_n       = '0;
      stk_vld_n = 1'b0;
      cef_n     = 1'b0;
      cv_n      = 1'b0;
      // A read in flight is abandoned: drop the request for one cycle so the
      // arbiter sees a fresh request at address 0.
      rd_n      = ~rd_q;
    end else begin
      case (state_q)
        IDLE: ;
        RD_CTRL: begin
          if (!rd_q) begin
            rd_n = 1'b1;
          end else if (VRAM_RDY) begin
            cap_en = 1'b1;
            if (VRAM_D[15]) begin
              lopr_n  = {t_q, 2'b00};
              cef_n   = 1'b1;
              rd_n    = 1'b0;
              state_n = IDLE;
            end else begin
              w_n     = 4'd1;
              state_n = RD_LINK;
            end
          end
        end
        RD_LINK: begin
          if (!rd_q) begin
            rd_n = 1'b1;
          end else if (VRAM_RDY) begin
            cap_en = 1'b1;
            if (tbl_q[0][14]) begin
              rd_n    = 1'b0;
              state_n = LINK;
            end else begin
              w_n     = 4'd2;
              state_n = RD_BODY;
            end
          end
        end
        RD_BODY: begin
          if (!rd_q) begin
            rd_n = 1'b1;
          end else if (VRAM_RDY) begin
            cap_en = 1'b1;
            if (w_q == LAST_W) begin
              rd_n = 1'b0;
              if (comm_ok(tbl_q[0][3:0])) begin
                cv_n    = 1'b1;
                state_n = DISPATCH;
              end else begin
                state_n = LINK;
              end
            end else begin
              w_n = w_q + 4'd1;
            end
          end
        end
        DISPATCH: begin
          if (CMD_READY) begin
            cv_n    = 1'b0;
            state_n = LINK;
          end
        end
        LINK: begin
          w_n     = '0;
          rd_n    = 1'b1;
          state_n = RD_CTRL;
          case (tbl_q[0][13:12])
            2'd0: t_n = t_inc;
            2'd1: t_n = tbl_q[1][15:2];
            2'd2: begin
              stk_n     = t_inc;
              stk_vld_n = 1'b1;
              t_n       = tbl_q[1][15:2];
            end
            default: begin
              if (stk_vld_q) begin
                t_n       = stk_q;
                stk_vld_n = 1'b0;
              end else begin
                t_n = t_inc;
              end
            end
          endcase
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      t_q       <= '0;
      w_q       <= '0;
      rd_q      <= 1'b0;
      cv_q      <= 1'b0;
      busy_q    <= 1'b0;
      cef_q     <= 1'b0;
      bef_q     <= 1'b0;
      lopr_q    <= '0;
      stk_q     <= '0;
      stk_vld_q <= 1'b0;
      for (int i = 0; i < TBL_WORDS; i++) tbl_q[i] <= '0;
    end else begin
      state_q   <= state_n;
      t_q       <= t_n;
      w_q       <= w_n;
      rd_q      <= rd_n;
      cv_q      <= cv_n;
      busy_q    <= (state_n != IDLE);
      cef_q     <= cef_n;
      bef_q     <= bef_n;
      lopr_q    <= lopr_n;
      stk_q     <= stk_n;
      stk_vld_q <= stk_vld_n;
      if (cap_en) tbl_q[w_q] <= VRAM_D & word_mask(w_q);
    end
  end

  always_comb begin
    CMD_TBL = '0;
    for (int i = 0; i < TBL_WORDS; i++) CMD_TBL[255 - 16*i -: 16] = tbl_q[i];
  end

  // VRAM address is the table index concatenated with the word counter.
  assign VRAM_A    = {t_q, w_q};
  assign VRAM_RD   = rd_q;
  assign CMD_VALID = cv_q;
  assign COPR      = {t_q, 2'b00};
  assign LOPR      = lopr_q;
  assign CEF       = cef_q;
  assign BEF       = bef_q;
  assign BUSY      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vdp1_cmd_seq.sv
// Bench for vdp1_cmd_seq: a VRAM responder (optional random wait states and
// stray VRAM_RDY pulses while no read is pending) plus directed command lists.
module tb_vdp1_cmd_seq;

  logic         clk, rst;
  logic         start, frame_swap;
  logic [17:0]  vram_a;
  logic         vram_rd, vram_rdy;
  logic [15:0]  vram_d;
  logic [255:0] cmd_tbl;
  logic         cmd_valid, cmd_ready;
  logic [15:0]  copr, lopr;
  logic         cef, bef, busy;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] vmem [logic [17:0]];
  logic [17:0] rd_log [$];
  bit          wait_mode = 0;
  bit          spurious  = 0;
  bit          seen_valid = 0;

  vdp1_cmd_seq #(.TBL_WORDS(15)) dut (
    .CLK(clk), .RST(rst), .START(start), .FRAME_SWAP(frame_swap),
    .VRAM_A(vram_a), .VRAM_RD(vram_rd), .VRAM_RDY(vram_rdy), .VRAM_D(vram_d),
    .CMD_TBL(cmd_tbl), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .COPR(copr), .LOPR(lopr), .CEF(cef), .BEF(bef), .BUSY(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- VRAM model ----------------
  function automatic logic [15:0] body(input logic [13:0] t, input logic [3:0] w);
    body = {t[11:0], w} ^ 16'hE0E0;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    mem_rd = vmem.exists(a) ? vmem[a] : 16'h0000;
  endfunction

  function automatic logic [255:0] exp_tbl(input logic [13:0] t, input logic [15:0] ctrl,
                                           input logic [15:0] link);
    logic [255:0] r;
    logic [15:0]  wd;
    r = '0;
    for (int w = 0; w < 15; w++) begin
      if (w == 0)      wd = ctrl & 16'hFF3F;
      else if (w == 1) wd = link & 16'hFFFC;
      else begin
        wd = body(t, 4'(w));
        if (w == 2) wd = wd & 16'h9FFF;
        if (w == 5) wd = wd & 16'h3FFF;
      end
      r[255 - 16*w -: 16] = wd;
    end
    return r;
  endfunction

  task automatic write_table(input logic [13:0] t, input logic [15:0] ctrl, input logic [15:0] link);
    vmem[{t, 4'd0}] = ctrl;
    vmem[{t, 4'd1}] = link;
    for (int w = 2; w < 15; w++) vmem[{t, 4'(w)}] = body(t, 4'(w));
    vmem[{t, 4'd15}] = 16'hDEAD;
  endtask

  // Responder: decides VRAM_RDY for the coming edge on each falling edge.
  initial begin
    vram_rdy = 0;
    vram_d   = 0;
    forever begin
      @(negedge clk);
      if (vram_rd) begin
        if (!wait_mode || $urandom_range(0, 2) == 0) begin
          vram_rdy = 1;
          vram_d   = mem_rd(vram_a);
          rd_log.push_back(vram_a);
        end else begin
          vram_rdy = 0;
          vram_d   = 16'h0000;
        end
      end else if (spurious) begin
        vram_rdy = 1;
        vram_d   = 16'hFFFF;
      end else begin
        vram_rdy = 0;
      end
      if (cmd_valid) seen_valid = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic pulse_swap();
    @(negedge clk);
    frame_swap = 1;
    @(posedge clk);
    #1 frame_swap = 0;
  endtask

  // Waits on falling edges for CMD_VALID; n is the number of falling edges seen.
  task automatic wait_valid(output bit ok, output int n);
    ok = 0;
    n  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (cmd_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Called at a falling edge where CMD_VALID is high; transfer on next edge.
  task automatic accept();
    cmd_ready = 1;
    @(posedge clk);
    #1 cmd_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; start = 0; frame_swap = 0; cmd_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (vram_rd !== 1'b0) begin bad++; $display("FAIL reset_vram_rd: got %b want 0", vram_rd); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    total++; if ({busy, cef, bef} !== 3'b000) begin bad++; $display("FAIL reset_flags: busy/cef/bef got %b want 000", {busy, cef, bef}); end
    total++; if (vram_a !== 18'h0) begin bad++; $display("FAIL reset_vram_a: got %h want 00000", vram_a); end
    total++; if ({copr, lopr} !== 32'h0) begin bad++; $display("FAIL reset_copr_lopr: got %h want 0", {copr, lopr}); end
    total++; if (cmd_tbl !== 256'h0) begin bad++; $display("FAIL reset_cmd_tbl: got %h want 0", cmd_tbl); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 0;
  endtask

  task automatic test_linear();
    bit ok; int n;
    vmem.delete();
    write_table(14'd0, 16'h0000, 16'h0000);
    write_table(14'd1, 16'h00C4, 16'h0000);   // bits 7:6 masked away -> COMM=4
    write_table(14'd2, 16'h8000, 16'h0000);
    pulse_start();
    @(negedge clk);
    total++; if (vram_rd !== 1'b1 || vram_a !== 18'h0) begin bad++; $display("FAIL lin_first_read: rd=%b a=%h want rd=1 a=00000", vram_rd, vram_a); end
    total++; if (cef !== 1'b0) begin bad++; $display("FAIL lin_cef_clear: got %b want 0", cef); end
    // word 0 is taken on this cycle's edge, word 14 fourteen edges later; valid
    // appears in the following cycle -> 15 more falling edges.
    wait_valid(ok, n);
    total++; if (!ok || n != 15) begin bad++; $display("FAIL lin_latency: got ok=%b n=%0d want ok=1 n=15", ok, n); end
    total++; if (copr !== 16'h0000) begin bad++; $display("FAIL lin_copr0: got %h want 0000", copr); end
    total++; if (cmd_tbl !== exp_tbl(14'd0, 16'h0000, 16'h0000)) begin bad++; $display("FAIL lin_tbl0: got %h want %h", cmd_tbl, exp_tbl(14'd0, 16'h0000, 16'h0000)); end
    accept();
    @(negedge clk);
    total++; if (vram_rd !== 1'b0 || cmd_valid !== 1'b0) begin bad++; $display("FAIL lin_link_cycle: rd=%b valid=%b want 0 0", vram_rd, cmd_valid); end
    @(negedge clk);
    total++; if (vram_rd !== 1'b1 || vram_a !== 18'h00010) begin bad++; $display("FAIL lin_next_read: rd=%b a=%h want 1 00010", vram_rd, vram_a); end
    wait_valid(ok, n);
    total++; if (!ok || copr !== 16'h0004) begin bad++; $display("FAIL lin_copr1: ok=%b got %h want 0004", ok, copr); end
    total++; if (cmd_tbl !== exp_tbl(14'd1, 16'h00C4, 16'h0000)) begin bad++; $display("FAIL lin_tbl1: got %h want %h", cmd_tbl, exp_tbl(14'd1, 16'h00C4, 16'h0000)); end
    accept();
    wait_idle(ok);
    total++; if (!ok || lopr !== 16'h0008) begin bad++; $display("FAIL lin_lopr: ok=%b got %h want 0008", ok, lopr); end
    total++; if (cef !== 1'b1 || cmd_valid !== 1'b0) begin bad++; $display("FAIL lin_end_flags: cef=%b valid=%b want 1 0", cef, cmd_valid); end
  endtask

  task automatic test_jump();
    bit ok; int n;
    vmem.delete();
    write_table(14'd0, 16'h1000, 16'h0103);   // JP=1, link 0x0103 -> 0x0100 -> table 0x40
    write_table(14'h40, 16'h8000, 16'h0000);
    pulse_start();
    wait_valid(ok, n);
    total++; if (!ok || cmd_tbl !== exp_tbl(14'd0, 16'h1000, 16'h0103)) begin bad++; $display("FAIL jmp_tbl: ok=%b got %h want %h", ok, cmd_tbl, exp_tbl(14'd0, 16'h1000, 16'h0103)); end
    accept();
    @(negedge clk);
    @(negedge clk);
    total++; if (vram_a !== 18'h00400 || vram_rd !== 1'b1) begin bad++; $display("FAIL jmp_addr: a=%h rd=%b want 00400 1", vram_a, vram_rd); end
    total++; if (copr !== 16'h0100) begin bad++; $display("FAIL jmp_copr: got %h want 0100", copr); end
    wait_idle(ok);
    total++; if (!ok || lopr !== 16'h0100) begin bad++; $display("FAIL jmp_lopr: ok=%b got %h want 0100", ok, lopr); end
  endtask

  task automatic test_call_return();
    bit ok; int n;
    logic [15:0] exp_copr [3];
    exp_copr[0] = 16'h0000; exp_copr[1] = 16'h0040; exp_copr[2] = 16'h0004;
    vmem.delete();
    write_table(14'd0, 16'h2000, 16'h0040);   // call table 0x10
    write_table(14'h10, 16'h3000, 16'h0000);  // return -> table 1
    write_table(14'd1, 16'h3000, 16'h0000);   // return, stack empty -> table 2
    write_table(14'd2, 16'h8000, 16'h0000);
    wait_mode = 1; spurious = 1;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok, n);
      total++; if (!ok || copr !== exp_copr[k]) begin bad++; $display("FAIL call_copr%0d: ok=%b got %h want %h", k, ok, copr, exp_copr[k]); end
      if (k == 1) begin
        total++; if (cmd_tbl !== exp_tbl(14'h10, 16'h3000, 16'h0000)) begin bad++; $display("FAIL call_tbl: got %h want %h", cmd_tbl, exp_tbl(14'h10, 16'h3000, 16'h0000)); end
      end
      accept();
    end
    wait_idle(ok);
    total++; if (!ok || lopr !== 16'h0008) begin bad++; $display("FAIL call_lopr: ok=%b got %h want 0008", ok, lopr); end
    wait_mode = 0; spurious = 0;
  endtask

  task automatic test_skip_noop();
    bit ok;
    int t0_reads;
    vmem.delete();
    write_table(14'd0, 16'h4000, 16'h0000);   // skip
    write_table(14'd1, 16'h0007, 16'h0000);   // COMM=7 no-op
    write_table(14'd2, 16'h8000, 16'h0000);
    rd_log.delete();
    pulse_start();
    seen_valid = 0;
    wait_idle(ok);
    t0_reads = 0;
    foreach (rd_log[i]) if (rd_log[i][17:4] == 14'd0) t0_reads++;
    total++; if (!ok || seen_valid !== 1'b0) begin bad++; $display("FAIL skip_no_valid: ok=%b seen_valid=%b want 1 0", ok, seen_valid); end
    total++; if (t0_reads != 2) begin bad++; $display("FAIL skip_t0_reads: got %0d want 2", t0_reads); end
    total++; if (rd_log.size() != 18) begin bad++; $display("FAIL skip_total_reads: got %0d want 18", rd_log.size()); end
    total++; if (lopr !== 16'h0008) begin bad++; $display("FAIL skip_lopr: got %h want 0008", lopr); end
  endtask

  task automatic test_backpressure_restart();
    bit ok; int n;
    int unstable;
    logic [255:0] e0;
    vmem.delete();
    write_table(14'd0, 16'h0001, 16'h0000);
    write_table(14'd1, 16'h2002, 16'h0040);   // call table 0x10, stack <- 2
    write_table(14'h10, 16'h0000, 16'h0000);
    e0 = exp_tbl(14'd0, 16'h0001, 16'h0000);
    pulse_start();
    wait_valid(ok, n);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_tbl !== e0 || copr !== 16'h0000) unstable++;
    end
    total++; if (!ok || unstable != 0) begin bad++; $display("FAIL bp_stable: ok=%b unstable_cycles=%0d want 0", ok, unstable); end
    accept();
    wait_valid(ok, n);
    total++; if (!ok || copr !== 16'h0004) begin bad++; $display("FAIL bp_copr1: ok=%b got %h want 0004", ok, copr); end
    accept();
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vram_a == 18'h00105) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL bp_reach_midfetch: got no read at 00105 want one"); end
    // Table 0 now returns: with a cleared stack that lands on table 1 (END).
    vmem[18'h00000] = 16'h3000;
    vmem[18'h00010] = 16'h8000;
    pulse_start();
    @(negedge clk);
    total++; if (vram_rd !== 1'b0 || cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_drop: rd=%b valid=%b want 0 0", vram_rd, cmd_valid); end
    @(negedge clk);
    total++; if (vram_rd !== 1'b1 || vram_a !== 18'h0 || copr !== 16'h0) begin bad++; $display("FAIL rst_addr0: rd=%b a=%h copr=%h want 1 00000 0000", vram_rd, vram_a, copr); end
    wait_valid(ok, n);
    total++; if (!ok || copr !== 16'h0000) begin bad++; $display("FAIL rst_copr: ok=%b got %h want 0000", ok, copr); end
    accept();
    @(negedge clk);
    @(negedge clk);
    total++; if (vram_a !== 18'h00010) begin bad++; $display("FAIL rst_stack_cleared: a=%h want 00010", vram_a); end
    wait_idle(ok);
    total++; if (!ok || lopr !== 16'h0004) begin bad++; $display("FAIL rst_lopr: ok=%b got %h want 0004", ok, lopr); end
  endtask

  task automatic test_frame_flags();
    bit ok;
    vmem.delete();
    write_table(14'd0, 16'h8000, 16'h0000);
    // CEF=1, BEF=0 here. START together with FRAME_SWAP.
    wait_mode = 1;
    @(negedge clk);
    start = 1; frame_swap = 1;
    @(posedge clk);
    #1 start = 0; frame_swap = 0;
    @(negedge clk);
    total++; if (bef !== 1'b1 || cef !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fr_start_swap: bef=%b cef=%b busy=%b want 1 0 1", bef, cef, busy); end
    wait_idle(ok);
    total++; if (!ok || cef !== 1'b1) begin bad++; $display("FAIL fr_end_same_edge: ok=%b cef=%b want 1 1", ok, cef); end
    total++; if (lopr !== 16'h0000) begin bad++; $display("FAIL fr_lopr: got %h want 0000", lopr); end
    // FRAME_SWAP on the END edge (zero-wait: END taken one edge after START).
    wait_mode = 0;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0; frame_swap = 1;
    @(posedge clk);
    #1 frame_swap = 0;
    @(negedge clk);
    total++; if ({busy, cef, bef} !== 3'b010) begin bad++; $display("FAIL fr_swap_at_end: busy/cef/bef got %b want 010", {busy, cef, bef}); end
    pulse_swap();
    @(negedge clk);
    total++; if (bef !== 1'b1 || cef !== 1'b0) begin bad++; $display("FAIL fr_swap1: bef=%b cef=%b want 1 0", bef, cef); end
    pulse_swap();
    @(negedge clk);
    total++; if (bef !== 1'b0 || cef !== 1'b0) begin bad++; $display("FAIL fr_swap2: bef=%b cef=%b want 0 0", bef, cef); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_linear();
    test_jump();
    test_call_return();
    test_skip_noop();
    test_backpressure_restart();
    test_frame_flags();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
